// File: rtl/bram_stream_reader.sv
// Read-side sequencer for a 1-cycle-latency BRAM: sweeps an address window and streams words out with valid/ready backpressure.
// Optional end-of-window flag: define BRAM_RD_LAST_EN to add the m_last port.
module bram_stream_reader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] bram_raddr,
  input  logic [DATA_WIDTH-1:0] bram_data_out,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
`ifdef BRAM_RD_LAST_EN
  ,
  output logic                  m_last
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  rd_pending;
  logic [1:0]            fifo_count;
  logic [DATA_WIDTH-1:0] entry0;
  logic [DATA_WIDTH-1:0] entry1;

  logic       pop;
  logic       push;
  logic       issue;
  logic       last_issue;
  logic       last_pop;
  logic [2:0] credit;
  logic       wr0_new;
  logic       wr1_new;
  logic       shift;
  logic [1:0] count_next;

  assign pop        = m_valid & m_ready;
  assign push       = rd_pending;
  assign m_valid    = (fifo_count != 2'd0);
  assign m_data     = entry0;
  assign busy       = (state != S_IDLE);
  assign bram_raddr = addr;

  // Occupancy seen by the next read: words held plus the one in flight, less the one leaving now.
  assign credit     = 3'(fifo_count) + 3'(rd_pending) - 3'(pop);
  assign issue      = (state == S_RUN) && (remaining != '0) && (credit < 3'd2);
  assign last_issue = issue && (remaining == (ADDR_WIDTH+1)'(1));
  assign last_pop   = (state == S_DRAIN) && pop && (fifo_count == 2'd1) && !rd_pending;

  // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    wr0_new    = 1'b0;
    wr1_new    = 1'b0;
    shift      = 1'b0;
    count_next = fifo_count;
    if (push) begin
      wr0_new = (fifo_count == 2'd0) || (pop && fifo_count == 2'd1);
      wr1_new = (!pop && fifo_count == 2'd1) || (pop && fifo_count == 2'd2);
    end
    shift = pop && !wr0_new;
    if (push && !pop) begin
      count_next = fifo_count + 2'd1;
    end else if (!push && pop) begin
      count_next = fifo_count - 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      addr       <= '0;
      remaining  <= '0;
      rd_pending <= 1'b0;
      done       <= 1'b0;
    end else begin
      done       <= 1'b0;
      rd_pending <= issue;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              state     <= S_RUN;
              addr      <= start_addr;
              remaining <= len;
            end
          end
        end
        S_RUN: begin
          if (issue) begin
            addr      <= addr + ADDR_WIDTH'(1);
            remaining <= remaining - (ADDR_WIDTH+1)'(1);
          end
          if (last_issue) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (last_pop) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the FIFO words are reset too, because entry0 drives m_data which must read 0 after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fifo_count <= 2'd0;
      entry0     <= '0;
      entry1     <= '0;
    end else begin
      fifo_count <= count_next;
      if (wr0_new) begin
        entry0 <= bram_data_out;
      end else if (shift) begin
        entry0 <= entry1;
      end
      if (wr1_new) begin
        entry1 <= bram_data_out;
      end
    end
  end

`ifdef BRAM_RD_LAST_EN
  // End-of-window tag travels alongside each word: in flight, then in the FIFO slot.
  logic rd_last;
  logic tag0;
  logic tag1;

  assign m_last = tag0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_last <= 1'b0;
      tag0    <= 1'b0;
      tag1    <= 1'b0;
    end else begin
      rd_last <= last_issue;
      if (wr0_new) begin
        tag0 <= rd_last;
      end else if (shift) begin
        tag0 <= tag1;
      end
      if (wr1_new) begin
        tag1 <= rd_last;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: BRAM model, window-level expected-word queue checked every cycle, plus directed timing checks.
module tb_bram_stream_reader;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   len = '0;
  logic          m_ready = 1'b1;
  logic          busy;
  logic          done;
  logic [AW-1:0] bram_raddr;
  logic [DW-1:0] bram_data_out;
  logic [DW-1:0] m_data;
  logic          m_valid;
`ifdef BRAM_RD_LAST_EN
  logic          m_last;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [16];
  logic [DW-1:0] exp_q [$];
  bit            busy_m = 1'b0;
  bit            done_m = 1'b0;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;

  bram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .start_addr    (start_addr),
    .len           (len),
    .busy          (busy),
    .done          (done),
    .bram_raddr    (bram_raddr),
    .bram_data_out (bram_data_out),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready)
`ifdef BRAM_RD_LAST_EN
    ,
    .m_last        (m_last)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = DW'(i + 16);
  end

  always @(posedge clk) bram_data_out <= mem[bram_raddr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a started window is the queue of words it must deliver; each handshake pops the head.
  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(busy_m));
    check("done", 32'(done), 32'(done_m));
    if (stall_prev) begin
      check("stall_valid", 32'(m_valid), 32'd1);
      check("stall_data", 32'(m_data), 32'(prev_data));
    end
    if (m_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(m_valid), 32'd0);
      end else begin
        check("data", 32'(m_data), 32'(exp_q[0]));
`ifdef BRAM_RD_LAST_EN
        check("last", 32'(m_last), 32'(exp_q.size() == 1));
`endif
      end
    end else begin
      check("valid_idle", 32'(m_valid), 32'd0);
    end

    if (!rst_n) begin
      busy_m     = 1'b0;
      done_m     = 1'b0;
      stall_prev = 1'b0;
      exp_q.delete();
    end else begin
      done_m = 1'b0;
      if (busy_m && m_valid === 1'b1 && m_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          busy_m = 1'b0;
          done_m = 1'b1;
        end
      end else if (!busy_m && start) begin
        if (len == '0) begin
          done_m = 1'b1;
        end else begin
          busy_m = 1'b1;
          for (int k = 0; k < int'(len); k++) exp_q.push_back(mem[(int'(start_addr) + k) % 16]);
        end
      end
      stall_prev = (m_valid === 1'b1) && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller in cycle 1 (the cycle after start was sampled).
  task automatic launch(input logic [AW-1:0] sa, input logic [AW:0] ln);
    start      = 1'b1;
    start_addr = sa;
    len        = ln;
    tick;
    start      = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input bit toggle);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      m_ready = toggle ? ((i % 4) == 0 || (i % 4) == 3) : 1'b1;
      tick;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    m_ready = 1'b1;
    check("done_reached", 32'(seen), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    repeat (3) tick;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_raddr", 32'(bram_raddr), 32'd0);
`ifdef BRAM_RD_LAST_EN
    check("rst_last", 32'(m_last), 32'd0);
`endif
    rst_n = 1'b1;
    tick;

    // Basic window, full throughput
    launch(4'd2, 5'd5);
    check("t1_raddr_c1", 32'(bram_raddr), 32'd2);
    check("t1_busy_c1", 32'(busy), 32'd1);
    tick;
    check("t1_valid_c2", 32'(m_valid), 32'd0);
    for (int c = 3; c <= 7; c++) begin
      tick;
      check("t1_valid", 32'(m_valid), 32'd1);
      check("t1_data", 32'(m_data), 32'(8'h12 + c - 3));
    end
    tick;
    check("t1_done_c8", 32'(done), 32'd1);
    check("t1_busy_c8", 32'(busy), 32'd0);
    check("t1_valid_c8", 32'(m_valid), 32'd0);
    tick;
    check("t1_done_once", 32'(done), 32'd0);

    // Same window under ready pattern 1,0,0,1
    launch(4'd2, 5'd5);
    run_until_done(80, 1'b1);
    check("t2_drained", 32'(exp_q.size()), 32'd0);
    tick;

    // Address wrap
    launch(4'd14, 5'd4);
    check("t3_raddr0", 32'(bram_raddr), 32'd14);
    tick;
    check("t3_raddr1", 32'(bram_raddr), 32'd15);
    tick;
    check("t3_raddr2", 32'(bram_raddr), 32'd0);
    check("t3_data0", 32'(m_data), 32'h1e);
    tick;
    check("t3_raddr3", 32'(bram_raddr), 32'd1);
    run_until_done(40, 1'b0);

    // Empty and full-size windows
    launch(4'd5, 5'd0);
    check("t4_done_len0", 32'(done), 32'd1);
    check("t4_busy_len0", 32'(busy), 32'd0);
    tick;
    check("t4_done_len0_once", 32'(done), 32'd0);
    launch(4'd0, 5'd16);
    run_until_done(80, 1'b0);
    tick;

    // Mid-transfer reset, then recovery and ignored start while busy
    launch(4'd0, 5'd8);
    repeat (4) tick;
    check("t5_head_before_rst", 32'(m_data), 32'h12);
    rst_n = 1'b0;
    tick;
    check("t5_valid_rst", 32'(m_valid), 32'd0);
    check("t5_busy_rst", 32'(busy), 32'd0);
    check("t5_done_rst", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (3) begin
      tick;
      check("t5_no_done", 32'(done), 32'd0);
    end
    launch(4'd4, 5'd3);
    tick;
    start      = 1'b1;
    start_addr = 4'd9;
    len        = 5'd5;
    tick;
    start = 1'b0;
    run_until_done(40, 1'b0);
    tick;

    // Final-word flag held under backpressure
    m_ready = 1'b0;
    launch(4'd0, 5'd3);
    repeat (4) tick;
    check("t6_head_stalled", 32'(m_data), 32'h10);
`ifdef BRAM_RD_LAST_EN
    check("t6_last_first", 32'(m_last), 32'd0);
`endif
    m_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (m_valid === 1'b1 && m_data == 8'h12) begin
        m_ready = 1'b0;
        found = 1'b1;
        break;
      end
    end
    check("t6_third_seen", 32'(found), 32'd1);
    repeat (3) begin
      tick;
      check("t6_hold_valid", 32'(m_valid), 32'd1);
      check("t6_hold_data", 32'(m_data), 32'h12);
`ifdef BRAM_RD_LAST_EN
      check("t6_hold_last", 32'(m_last), 32'd1);
`endif
    end
    run_until_done(20, 1'b0);

    repeat (2) tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
